scratch_mem_arbiter: RTL

//  Shares the single-port 64-entry scratch memory between the three histogram-equalization

---
 rtl/scratch_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/scratch_mem_arbiter.sv
// Round-robin arbiter sharing the single-port histogram scratch memory between
// the accumulator (0), cdf datapath (1) and mapping unit (2).
//
// state | meaning
// ARB   | no owner; pick next requester after last, gnt low
// OWN   | requester `last` holds the grant; its accesses go to memory
module scratch_mem_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 20,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        req,
   input  logic [2:0]        lock,
   input  logic [2:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic [2:0]        gnt,
   output logic [2:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {ARB, OWN} state_t;

   state_t            state;
   logic [1:0]        last;
   logic [HOLD_W-1:0] hold_cnt;
   logic [1:0]        winner;
   logic              accept;
   logic              own_req;
   logic              own_lock;
   logic              others_pending;
   logic              release_now;

   // gnt is one-hot and zero in ARB, so masking with it selects the owner
   assign own_req        = |(req & gnt);
   assign own_lock       = |(lock & gnt);
   assign others_pending = |(req & ~gnt);
   assign accept         = (state == OWN) && own_req;
   assign release_now    = !own_lock && (!own_req || ((hold_cnt >= HOLD_LAST) && others_pending));
   assign rdata          = mem_rdata;

   always_comb begin
      winner = 2'd0;
      case (last)
         2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      mem_en    = accept;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (accept) begin
         case (last)
            2'd0: begin
               mem_we    = we[0];
               mem_addr  = addr0;
               mem_wdata = wdata0;
            end
            2'd1: begin
               mem_we    = we[1];
               mem_addr  = addr1;
               mem_wdata = wdata1;
            end
            default: begin
               mem_we    = we[2];
               mem_addr  = addr2;
               mem_wdata = wdata2;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB;
         gnt      <= 3'b000;
         rvalid   <= 3'b000;
         hold_cnt <= '0;
         last     <= 2'd2;
      end else begin
         // read tag follows the grant that issued it, not the current grant
         rvalid <= (accept && !mem_we) ? gnt : 3'b000;
         if (state == ARB) begin
            if (|req) begin
               gnt      <= 3'b001 << winner;
               last     <= winner;
               hold_cnt <= '0;
               state    <= OWN;
            end else begin
               gnt <= 3'b000;
            end
         end else begin
            if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
            if (release_now) begin
               gnt   <= 3'b000;
               state <= ARB;
            end
         end
      end
   end

endmodule
